// File: rtl/pkt_buffer_writer_pkg.sv
// Shared types for the packet buffer writer: flit and metadata bundles,
// FSM state encoding and the per-slot flit limit.
package pkt_buffer_writer_pkg;

   localparam int MAX_FLITS = 32;
   localparam int PKT_ID_W  = 10;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      META
   } state_e;

   typedef struct packed {
      logic         sop;
      logic         eop;
      logic [5:0]   empty;
      logic [511:0] data;
   } flit_t;

   typedef struct packed {
      logic [PKT_ID_W-1:0] pkt_id;
      logic [5:0]          flits;
      logic [15:0]         len;
      logic                trunc;
   } wr_meta_t;

endpackage

// File: rtl/pkt_buffer_writer_stats_cnt.sv
// Free-running 32-bit event counter, wraps modulo 2^32.
module stats_cnt (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        inc,
   output logic [31:0] cnt
);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) cnt <= '0;
      else if (inc) cnt <= cnt + 32'd1;
   end

endmodule

// File: rtl/pkt_buffer_writer.sv
// Writes ingress flits into a slot-addressed packet buffer and emits metadata.
// Optional statistics counters: define PKT_WRITER_STATS_EN.
module pkt_buffer_writer
   import pkt_buffer_writer_pkg::*;
#(
   parameter int PKTBUF_AWIDTH = 15,
   parameter int PKT_AWIDTH    = 10
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     in_pkt_sop,
   input  logic                     in_pkt_eop,
   input  logic                     in_pkt_valid,
   input  logic [511:0]             in_pkt_data,
   input  logic [5:0]               in_pkt_empty,
   output logic                     in_pkt_ready,
   input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
   input  logic                     emptylist_out_valid,
   output logic                     emptylist_out_ready,
   output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
   output logic                     pkt_buffer_write,
   output flit_t                    pkt_buffer_writedata,
   output logic                     meta_valid,
   output wr_meta_t                 meta_data,
   input  logic                     meta_ready,
   output logic [31:0]              stats_in_pkt,
   output logic [31:0]              stats_out_meta,
   output logic [31:0]              stats_trunc_pkt,
   output logic [31:0]              stats_orphan_flit
);

   localparam int          IDXW    = PKTBUF_AWIDTH - PKT_AWIDTH;
   localparam logic [15:0] MAX_CNT = 16'(1 << IDXW);
   localparam logic [5:0]  MAX_F6  = 6'(1 << IDXW);

   state_e                state, state_n;
   logic [PKT_AWIDTH-1:0] pkt_id;
   logic [15:0]           cnt, cnt_p1;
   logic                  trunc, ovf;
   wr_meta_t              meta_q;
   logic                  acc_sop, acc_cont;
   flit_t                 flit;

   assign flit      = '{sop: in_pkt_sop, eop: in_pkt_eop,
                        empty: in_pkt_empty, data: in_pkt_data};
   assign cnt_p1    = cnt + 16'd1;
   assign ovf       = trunc | (cnt >= MAX_CNT);
   assign meta_data = meta_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state  <= IDLE;
         pkt_id <= '0;
         cnt    <= '0;
         trunc  <= 1'b0;
         meta_q <= '0;
      end else begin
         state <= state_n;
         if (acc_sop) begin
            pkt_id <= emptylist_out_data;
            cnt    <= 16'd1;
            trunc  <= 1'b0;
            if (in_pkt_eop)
               meta_q <= '{pkt_id: PKT_ID_W'(emptylist_out_data),
                           flits: 6'd1,
                           len: 16'd64 - 16'(in_pkt_empty),
                           trunc: 1'b0};
         end
         if (acc_cont) begin
            cnt   <= cnt_p1;
            trunc <= ovf;
            if (in_pkt_eop)
               meta_q <= '{pkt_id: PKT_ID_W'(pkt_id),
                           flits: ovf ? MAX_F6 : cnt_p1[5:0],
                           len: (cnt_p1 << 6) - 16'(in_pkt_empty),
                           trunc: ovf};
         end
      end
   end

   always_comb begin
      state_n              = state;
      in_pkt_ready         = 1'b0;
      emptylist_out_ready  = 1'b0;
      pkt_buffer_write     = 1'b0;
      pkt_buffer_address   = '0;
      pkt_buffer_writedata = '0;
      meta_valid           = 1'b0;
      acc_sop              = 1'b0;
      acc_cont             = 1'b0;
      unique case (state)
         IDLE: begin
            // orphans are always drained, even with no free slot
            in_pkt_ready = emptylist_out_valid
                         | (in_pkt_valid & ~in_pkt_sop);
            if (in_pkt_valid && in_pkt_sop && emptylist_out_valid) begin
               acc_sop             = 1'b1;
               emptylist_out_ready = 1'b1;
               pkt_buffer_write    = 1'b1;
               pkt_buffer_address  = {emptylist_out_data, IDXW'(0)};
               state_n             = in_pkt_eop ? META : WRITE;
            end
         end
         WRITE: begin
            in_pkt_ready = 1'b1;
            if (in_pkt_valid) begin
               acc_cont           = 1'b1;
               pkt_buffer_write   = ~ovf;
               pkt_buffer_address = {pkt_id, cnt[IDXW-1:0]};
               if (in_pkt_eop) state_n = META;
            end
         end
         META: begin
            meta_valid = 1'b1;
            if (meta_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (pkt_buffer_write) pkt_buffer_writedata = flit;
      if (!Rst_n) begin
         in_pkt_ready        = 1'b0;
         emptylist_out_ready = 1'b0;
         pkt_buffer_write    = 1'b0;
         pkt_buffer_address  = '0;
         pkt_buffer_writedata = '0;
         meta_valid          = 1'b0;
         acc_sop             = 1'b0;
         acc_cont            = 1'b0;
      end
   end

`ifdef PKT_WRITER_STATS_EN
   logic acc_orph, meta_hs;

   assign acc_orph = in_pkt_valid & in_pkt_ready & ~in_pkt_sop
                   & (state == IDLE);
   assign meta_hs  = meta_valid & meta_ready;

   stats_cnt u_in_pkt (.Clk(Clk), .Rst_n(Rst_n), .inc(acc_sop),
                       .cnt(stats_in_pkt));
   stats_cnt u_out_meta (.Clk(Clk), .Rst_n(Rst_n), .inc(meta_hs),
                         .cnt(stats_out_meta));
   stats_cnt u_trunc (.Clk(Clk), .Rst_n(Rst_n),
                      .inc(meta_hs & meta_q.trunc),
                      .cnt(stats_trunc_pkt));
   stats_cnt u_orphan (.Clk(Clk), .Rst_n(Rst_n), .inc(acc_orph),
                       .cnt(stats_orphan_flit));
`else
   assign stats_in_pkt      = '0;
   assign stats_out_meta    = '0;
   assign stats_trunc_pkt   = '0;
   assign stats_orphan_flit = '0;
`endif

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Directed bench for pkt_buffer_writer: per-cycle vector table plus
// truncation and mid-packet reset sequences.
module tb_pkt_buffer_writer;
   import pkt_buffer_writer_pkg::*;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic         Clk = 1'b0;
   logic         Rst_n = 1'b0;
   logic         in_pkt_sop, in_pkt_eop, in_pkt_valid;
   logic [511:0] in_pkt_data;
   logic [5:0]   in_pkt_empty;
   logic         in_pkt_ready;
   logic [9:0]   emptylist_out_data;
   logic         emptylist_out_valid, emptylist_out_ready;
   logic [14:0]  pkt_buffer_address;
   logic         pkt_buffer_write;
   flit_t        pkt_buffer_writedata;
   logic         meta_valid, meta_ready;
   wr_meta_t     meta_data;
   logic [31:0]  stats_in_pkt, stats_out_meta;
   logic [31:0]  stats_trunc_pkt, stats_orphan_flit;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   pkt_buffer_writer dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
      .in_pkt_valid(in_pkt_valid), .in_pkt_data(in_pkt_data),
      .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
      .emptylist_out_data(emptylist_out_data),
      .emptylist_out_valid(emptylist_out_valid),
      .emptylist_out_ready(emptylist_out_ready),
      .pkt_buffer_address(pkt_buffer_address),
      .pkt_buffer_write(pkt_buffer_write),
      .pkt_buffer_writedata(pkt_buffer_writedata),
      .meta_valid(meta_valid), .meta_data(meta_data),
      .meta_ready(meta_ready),
      .stats_in_pkt(stats_in_pkt), .stats_out_meta(stats_out_meta),
      .stats_trunc_pkt(stats_trunc_pkt),
      .stats_orphan_flit(stats_orphan_flit)
   );

   typedef struct packed {
      logic        sop, eop, v;
      logic [5:0]  emp;
      logic        elv;
      logic [9:0]  el;
      logic        mr;
      logic        e_rdy, e_wr, e_pop, e_mv;
      logic [14:0] e_addr;
      wr_meta_t    e_meta;
   } vec_t;

   vec_t tv [19];

   function automatic logic [511:0] dat(int i);
      return {16{32'hC0DE_0000 | 32'(i)}};
   endfunction

   function automatic wr_meta_t mm(logic [9:0] id, logic [5:0] f,
                                   logic [15:0] l, logic t);
      wr_meta_t m;
      m.pkt_id = id;
      m.flits  = f;
      m.len    = l;
      m.trunc  = t;
      return m;
   endfunction

   function automatic logic [14:0] ad(logic [9:0] id, logic [4:0] i);
      return {id, i};
   endfunction

   function automatic logic [31:0] es(logic [31:0] v);
`ifdef PKT_WRITER_STATS_EN
      return v;
`else
      return (v & 32'd0);
`endif
   endfunction

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic chkw(string n, flit_t a, flit_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, a, e);
      end
   endtask

   task automatic drive(logic sop, logic eop, logic v, logic [5:0] emp,
                        logic elv, logic [9:0] el, logic mr, int idx);
      in_pkt_sop          = sop;
      in_pkt_eop          = eop;
      in_pkt_valid        = v;
      in_pkt_empty        = emp;
      in_pkt_data         = dat(idx);
      emptylist_out_valid = elv;
      emptylist_out_data  = el;
      meta_ready          = mr;
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      wr_meta_t m0;
      logic [31:0] trunc_before;
      m0 = '0;

      tv[0]  = '{L,L,L,6'd0,H,10'd7,L, H,L,L,L, 15'd0, m0};
      tv[1]  = '{H,L,H,6'd0,H,10'd7,L, H,H,H,L, ad(10'd7,5'd0), m0};
      tv[2]  = '{L,L,H,6'd0,H,10'd9,L, H,H,L,L, ad(10'd7,5'd1), m0};
      tv[3]  = '{L,H,H,6'd10,H,10'd9,L, H,H,L,L, ad(10'd7,5'd2), m0};
      tv[4]  = '{L,L,L,6'd0,H,10'd9,L, L,L,L,H, 15'd0,
                 mm(10'd7,6'd3,16'd182,L)};
      tv[5]  = '{L,L,L,6'd0,H,10'd9,H, L,L,L,H, 15'd0,
                 mm(10'd7,6'd3,16'd182,L)};
      tv[6]  = '{H,H,H,6'd4,L,10'd3,H, L,L,L,L, 15'd0, m0};
      tv[7]  = '{H,H,H,6'd4,H,10'd3,H, H,H,H,L, ad(10'd3,5'd0), m0};
      for (int i = 8; i < 13; i++)
         tv[i] = '{H,H,H,6'd0,H,10'd5,L, L,L,L,H, 15'd0,
                   mm(10'd3,6'd1,16'd60,L)};
      tv[13] = '{H,H,H,6'd0,H,10'd5,H, L,L,L,H, 15'd0,
                 mm(10'd3,6'd1,16'd60,L)};
      tv[14] = '{H,H,H,6'd0,H,10'd5,L, H,H,H,L, ad(10'd5,5'd0), m0};
      tv[15] = '{L,L,L,6'd0,L,10'd0,H, L,L,L,H, 15'd0,
                 mm(10'd5,6'd1,16'd64,L)};
      tv[16] = '{L,L,H,6'd0,L,10'd0,L, H,L,L,L, 15'd0, m0};
      tv[17] = '{L,L,H,6'd0,H,10'd2,L, H,L,L,L, 15'd0, m0};
      tv[18] = '{L,L,L,6'd0,L,10'd0,L, L,L,L,L, 15'd0, m0};

      drive(L, L, L, 6'd0, L, 10'd0, L, 0);
      #12;
      chk("rst_ready", 64'(in_pkt_ready), 64'd0);
      chk("rst_mvalid", 64'(meta_valid), 64'd0);
      chk("rst_meta", 64'(meta_data), 64'd0);
      chk("rst_stats", 64'(stats_in_pkt | stats_out_meta
                            | stats_trunc_pkt | stats_orphan_flit), 64'd0);
      Rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 19; i++) begin
         drive(tv[i].sop, tv[i].eop, tv[i].v, tv[i].emp,
               tv[i].elv, tv[i].el, tv[i].mr, i);
         #3;
         chk($sformatf("row%0d_ready", i), 64'(in_pkt_ready),
             64'(tv[i].e_rdy));
         chk($sformatf("row%0d_write", i), 64'(pkt_buffer_write),
             64'(tv[i].e_wr));
         chk($sformatf("row%0d_pop", i), 64'(emptylist_out_ready),
             64'(tv[i].e_pop));
         chk($sformatf("row%0d_mvalid", i), 64'(meta_valid),
             64'(tv[i].e_mv));
         if (tv[i].e_wr) begin
            chk($sformatf("row%0d_addr", i), 64'(pkt_buffer_address),
                64'(tv[i].e_addr));
            chkw($sformatf("row%0d_wdata", i), pkt_buffer_writedata,
                 '{sop: tv[i].sop, eop: tv[i].eop, empty: tv[i].emp,
                   data: dat(i)});
         end
         if (tv[i].e_mv)
            chk($sformatf("row%0d_meta", i), 64'(meta_data),
                64'(tv[i].e_meta));
         cyc();
      end

      chk("stats_in_pkt", 64'(stats_in_pkt), 64'(es(32'd3)));
      chk("stats_out_meta", 64'(stats_out_meta), 64'(es(32'd3)));
      chk("stats_orphan", 64'(stats_orphan_flit), 64'(es(32'd2)));
      chk("stats_trunc0", 64'(stats_trunc_pkt), 64'd0);

      trunc_before = stats_trunc_pkt;
      for (int i = 0; i < 40; i++) begin
         drive(i == 0, i == 39, H, (i == 39) ? 6'd5 : 6'd0,
               H, 10'd11, L, 100 + i);
         #3;
         chk($sformatf("long%0d_write", i), 64'(pkt_buffer_write),
             64'(i < 32));
         chk($sformatf("long%0d_pop", i), 64'(emptylist_out_ready),
             64'(i == 0));
         if (i < 32)
            chk($sformatf("long%0d_addr", i), 64'(pkt_buffer_address),
                64'(ad(10'd11, 5'(i))));
         cyc();
      end
      drive(L, L, L, 6'd0, H, 10'd11, H, 0);
      #3;
      chk("long_mvalid", 64'(meta_valid), 64'd1);
      chk("long_meta", 64'(meta_data),
          64'(mm(10'd11, 6'd32, 16'd2555, H)));
      cyc();
      chk("long_trunc_stat", 64'(stats_trunc_pkt),
          64'(es(trunc_before + 32'd1)));
      chk("long_idle", 64'(meta_valid), 64'd0);

      for (int i = 0; i < 3; i++) begin
         drive(i == 0, L, H, 6'd0, H, 10'd13, H, 200 + i);
         if (i < 2) cyc();
      end
      #2;
      Rst_n = 1'b0;
      #1;
      chk("mrst_ready", 64'(in_pkt_ready), 64'd0);
      chk("mrst_write", 64'(pkt_buffer_write), 64'd0);
      chk("mrst_pop", 64'(emptylist_out_ready), 64'd0);
      chk("mrst_addr", 64'(pkt_buffer_address), 64'd0);
      chk("mrst_mvalid", 64'(meta_valid), 64'd0);
      chk("mrst_meta", 64'(meta_data), 64'd0);
      chk("mrst_stats", 64'(stats_in_pkt | stats_out_meta
                             | stats_trunc_pkt | stats_orphan_flit), 64'd0);
      drive(L, L, L, 6'd0, H, 10'd13, H, 0);
      cyc();
      Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("mrst_nometa%0d", i), 64'(meta_valid), 64'd0);
      end
      drive(H, L, H, 6'd0, L, 10'd0, H, 0);
      #3;
      chk("mrst_idle_ready", 64'(in_pkt_ready), 64'd0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
